// File: rtl/rw_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rw_sched_pkg
// Brief    : Shared types and helpers for the ReWire step scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package rw_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RSP  = 2'd1,
        S_HALT = 2'd2
    } sched_state_t;

    // Id width that stays at least one bit wide for degenerate requester counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rw_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rw_rr_arbiter
// Brief    : Combinational round-robin pick of the first request at/after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rw_rr_arbiter
    import rw_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        w_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = ID_W'((int'(ptr) + i) % N_REQ);
            if (!any && req[w_idx]) begin
                any        = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rw_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rw_step_scheduler
// Brief    : Round-robin sharing of one ReWire reactive device; one step per grant.
// Revision : 1.0 - initial release
// ============================================================================
module rw_step_scheduler
    import rw_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int IN_W  = 1,
    parameter  int OUT_W = 1,
    localparam int ID_W  = clog2_min1(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*IN_W-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [OUT_W-1:0]   rsp_data,
    output logic               dev_step,
    output logic [IN_W-1:0]    dev_in,
    input  logic [OUT_W-1:0]   dev_out,
    input  logic               dev_continue,
    output logic               halted
);

    sched_state_t      r_state;
    sched_state_t      w_next_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [OUT_W-1:0]  r_rsp_data;
    logic              r_halted;

    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_any;
    logic              w_fire;
    logic [IN_W-1:0]   w_words [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_words[gi] = req_data[gi*IN_W +: IN_W];
    end

    rw_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (r_rr_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id),
        .any    (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_fire       = 1'b0;
        req_ready    = '0;
        dev_step     = 1'b0;
        dev_in       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_fire       = 1'b1;
                    req_ready    = w_gnt;
                    dev_step     = 1'b1;
                    dev_in       = w_words[w_gnt_id];
                    w_next_state = dev_continue ? S_RSP : S_HALT;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Response capture happens on the same edge that steps the device, so
    // rsp_data reflects __out0 from the pre-step state and the granted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_halted    <= 1'b0;
        end else if (w_fire) begin
            r_rsp_data  <= dev_out;
            r_rsp_id    <= w_gnt_id;
            r_rsp_valid <= 1'b1;
            r_rr_ptr    <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
            if (!dev_continue) begin
                r_halted <= 1'b1;
            end
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign halted    = r_halted;

endmodule
`default_nettype wire
